dr32e_dec_trace_monitor: RTL

//  Passive monitor on the dr32e decoder outputs, successor of the empty decode monitor. Captures one

---
 rtl/dr32e_pkg.sv | 42 ++++
 rtl/dr32e_trace_fifo.sv | 76 +++++++
 rtl/dr32e_dec_trace_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dr32e_pkg.sv
// rtl/dr32e_pkg.sv - shared types for the dr32e decode trace monitor
package dr32e_pkg;

    typedef enum logic [2:0] {
        CNT_TOTAL    = 3'd0,
        CNT_ILLEGAL  = 3'd1,
        CNT_BRANCH   = 3'd2,
        CNT_BR_TAKEN = 3'd3,
        CNT_JUMP     = 3'd4,
        CNT_LOAD     = 3'd5,
        CNT_STORE    = 3'd6,
        CNT_MULDIV   = 3'd7
    } dec_mon_cnt_e;

    localparam int DEC_MON_NUM_CNT = 8;

    // Bit positions inside the record class byte
    localparam int CLS_ILLEGAL  = 0;
    localparam int CLS_BRANCH   = 1;
    localparam int CLS_BR_TAKEN = 2;
    localparam int CLS_JUMP     = 3;
    localparam int CLS_LOAD     = 4;
    localparam int CLS_STORE    = 5;
    localparam int CLS_MULDIV   = 6;
    localparam int CLS_SYSTEM   = 7;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rf_waddr;
        logic        rf_we;
        logic [7:0]  cls;
    } dec_trace_rec_t;

    localparam int DEC_TRACE_REC_W = $bits(dec_trace_rec_t);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } dec_mon_state_e;

endpackage

// File: rtl/dr32e_trace_fifo.sv
// rtl/dr32e_trace_fifo.sv - overwriting first-word-fall-through FIFO with sticky overflow flag
module dr32e_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 46
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             overflow_q;

    logic empty;
    logic full;
    logic pop_eff;
    logic drop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_eff = pop_i & ~empty;
    // Pushing into a full buffer with no pop evicts the oldest entry
    assign drop    = push_i & full & ~pop_eff;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_eff || drop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (push_i && !pop_eff && !full) begin
                count_q <= count_q + CW'(1);
            end else if (!push_i && pop_eff) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign valid_o    = ~empty;
    assign data_o     = empty ? '0 : mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/dr32e_dec_trace_monitor.sv
// rtl/dr32e_dec_trace_monitor.sv - passive decode trace buffer, event counters, illegal freeze
// Optional consistency checker enabled by defining DR32E_DEC_MON_CHECK_EN.
module dr32e_dec_trace_monitor
    import dr32e_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter bit FREEZE_ILL = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       mon_en_i,
    input  logic                       dec_valid_i,
    input  logic                       instr_first_cycle_i,
    input  logic [31:0]                instr_rdata_i,
    input  logic                       illegal_insn_i,
    input  logic                       ebrk_insn_i,
    input  logic                       ecall_insn_i,
    input  logic                       mret_insn_i,
    input  logic                       dret_insn_i,
    input  logic                       wfi_insn_i,
    input  logic                       jump_in_dec_i,
    input  logic                       branch_in_dec_i,
    input  logic                       branch_taken_i,
    input  logic                       data_req_i,
    input  logic                       data_we_i,
    input  logic                       mult_en_i,
    input  logic                       div_en_i,
    input  logic                       csr_access_i,
    input  logic                       rf_we_i,
    input  logic [4:0]                 rf_waddr_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [DEC_TRACE_REC_W-1:0] rd_data_o,
    output logic                       overflow_o,
    output logic                       frozen_o,
    input  logic [2:0]                 cnt_sel_i,
    output logic [CNT_W-1:0]           cnt_o,
    input  logic                       clr_i,
    output logic                       chk_err_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    dec_mon_state_e state_q;
    logic           cap;
    logic           muldiv;
    logic           sys_insn;
    dec_trace_rec_t rec;

    logic [DEC_MON_NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]           cnt_q [DEC_MON_NUM_CNT];
    logic [CNT_W-1:0]           cnt_d [DEC_MON_NUM_CNT];
    logic [CNT_W-1:0]           cnt_out_q;

    // Only the first ID cycle counts, so multi-cycle instructions are recorded once
    assign cap      = mon_en_i & dec_valid_i & instr_first_cycle_i & (state_q == S_RUN);
    assign muldiv   = mult_en_i | div_en_i;
    assign sys_insn = ebrk_insn_i | ecall_insn_i | mret_insn_i | dret_insn_i | wfi_insn_i | csr_access_i;

    always_comb begin
        rec                   = '0;
        rec.instr             = instr_rdata_i;
        rec.rf_waddr          = rf_waddr_i;
        rec.rf_we             = rf_we_i;
        rec.cls[CLS_ILLEGAL]  = illegal_insn_i;
        rec.cls[CLS_BRANCH]   = branch_in_dec_i;
        rec.cls[CLS_BR_TAKEN] = branch_taken_i;
        rec.cls[CLS_JUMP]     = jump_in_dec_i;
        rec.cls[CLS_LOAD]     = data_req_i & ~data_we_i;
        rec.cls[CLS_STORE]    = data_req_i & data_we_i;
        rec.cls[CLS_MULDIV]   = muldiv;
        rec.cls[CLS_SYSTEM]   = sys_insn;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else if (clr_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mon_en_i) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (!mon_en_i) begin
                        state_q <= S_IDLE;
                    end else if (cap && illegal_insn_i && FREEZE_ILL) begin
                        state_q <= S_FROZEN;
                    end
                end
                S_FROZEN: state_q <= S_FROZEN;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign frozen_o = (state_q == S_FROZEN);

    assign inc = {muldiv,
                  data_req_i & data_we_i,
                  data_req_i & ~data_we_i,
                  jump_in_dec_i,
                  branch_taken_i,
                  branch_in_dec_i,
                  illegal_insn_i,
                  1'b1};

    always_comb begin
        for (int i = 0; i < DEC_MON_NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_i) begin
                cnt_d[i] = '0;
            end else if (cap && inc[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEC_MON_NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            cnt_out_q <= '0;
        end else begin
            for (int i = 0; i < DEC_MON_NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            cnt_out_q <= cnt_q[cnt_sel_i];
        end
    end

    assign cnt_o = cnt_out_q;

    dr32e_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DEC_TRACE_REC_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .push_i     (cap & ~clr_i),
        .data_i     (rec),
        .pop_i      (rd_ready_i),
        .valid_o    (rd_valid_o),
        .data_o     (rd_data_o),
        .overflow_o (overflow_o)
    );

`ifdef DR32E_DEC_MON_CHECK_EN
    logic [5:0] sys_flags;
    logic       chk_hit;
    logic       chk_err_q;

    assign sys_flags = {illegal_insn_i, ebrk_insn_i, ecall_insn_i,
                        mret_insn_i, dret_insn_i, wfi_insn_i};
    // x & (x-1) is non-zero exactly when more than one flag is set
    assign chk_hit = ((sys_flags & (sys_flags - 6'd1)) != 6'd0)
                   | (jump_in_dec_i & branch_in_dec_i)
                   | (data_req_i & muldiv)
                   | (branch_taken_i & ~branch_in_dec_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chk_err_q <= 1'b0;
        end else if (clr_i) begin
            chk_err_q <= 1'b0;
        end else if (cap && chk_hit) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err_o = chk_err_q;
`else
    assign chk_err_o = 1'b0;
`endif

endmodule
